// File: rtl/as_pack.sv
// Shared types and sizes for the GPIO write-side controller.
package as_pack;

  localparam int nr_gpios        = 8;
  localparam int gpio_addr_width = 4;

  typedef struct packed {
    logic [gpio_addr_width-1:0] addr;
    logic [nr_gpios-1:0]        data;
  } gpio_wr_t;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    GAP
  } gpio_ctrl_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/as_sync_fifo.sv
// Single-clock FIFO with a count register for full/empty; pointers wrap naturally.
module as_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_count == CNT_W'(DEPTH));
  assign empty_o = (r_count == '0);
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign dout_o  = r_mem[r_rd_ptr];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the count alone.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= din_i;
  end

endmodule

// File: rtl/as_gpio_ctrl.sv
// GPIO write-side controller: buffers MEM-stage stores and sequences them onto
// the GPIO bus with a fixed cs_o high time and an idle gap between entries.
module as_gpio_ctrl
  import as_pack::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CS_HOLD    = 2,
  parameter int GAP_CYC    = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_req_i,
  input  logic [gpio_addr_width-1:0] wr_addr_i,
  input  logic [nr_gpios-1:0]        wr_data_i,
  output logic                       wr_ack_o,
  output logic                       stall_o,
  output logic [nr_gpios-1:0]        gpio_o,
  output logic [gpio_addr_width-1:0] gpioAddr_o,
  output logic                       cs_o,
  output logic                       busy_o
);

  localparam int CNT_W = $clog2(max_int(CS_HOLD, GAP_CYC) + 1);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = (GAP_CYC > 0) ? CNT_W'(GAP_CYC - 1) : '0;

  gpio_ctrl_state_t            r_state;
  gpio_ctrl_state_t            w_nxt_state;
  logic [CNT_W-1:0]            r_cnt;
  logic [CNT_W-1:0]            w_nxt_cnt;
  logic                        r_cs;
  logic                        w_nxt_cs;
  logic                        w_pop;
  logic                        w_full;
  logic                        w_empty;
  logic [$bits(gpio_wr_t)-1:0] w_fifo_dout;
  gpio_wr_t                    w_head;
  gpio_wr_t                    w_wr_entry;
  logic [nr_gpios-1:0]         r_gpio;
  logic [gpio_addr_width-1:0]  r_addr;

  // No bypass: a full FIFO refuses even when a pop happens on the same edge.
  assign wr_ack_o   = wr_req_i & ~w_full;
  assign stall_o    = wr_req_i & w_full;
  assign w_wr_entry = '{addr: wr_addr_i, data: wr_data_i};
  assign w_head     = gpio_wr_t'(w_fifo_dout);

  as_sync_fifo #(
    .WIDTH($bits(gpio_wr_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (wr_ack_o),
    .pop_i  (w_pop),
    .din_i  (w_wr_entry),
    .dout_o (w_fifo_dout),
    .full_o (w_full),
    .empty_o(w_empty)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_cs    <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_cs    <= w_nxt_cs;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_cs    = r_cs;
    w_pop       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_nxt_cs    = 1'b1;
          w_nxt_cnt   = HOLD_LD;
          w_nxt_state = DRIVE;
        end
      end
      DRIVE: begin
        if (r_cnt != '0) begin
          w_nxt_cnt = r_cnt - CNT_W'(1);
        end else if (GAP_CYC > 0) begin
          w_nxt_cs    = 1'b0;
          w_nxt_cnt   = GAP_LD;
          w_nxt_state = GAP;
        end else if (!w_empty) begin
          // Back-to-back entries keep cs_o asserted across the hand-over.
          w_pop     = 1'b1;
          w_nxt_cnt = HOLD_LD;
        end else begin
          w_nxt_cs    = 1'b0;
          w_nxt_state = IDLE;
        end
      end
      GAP: begin
        if (r_cnt != '0) begin
          w_nxt_cnt = r_cnt - CNT_W'(1);
        end else if (!w_empty) begin
          w_pop       = 1'b1;
          w_nxt_cs    = 1'b1;
          w_nxt_cnt   = HOLD_LD;
          w_nxt_state = DRIVE;
        end else begin
          w_nxt_state = IDLE;
        end
      end
      default: begin
        w_nxt_cs    = 1'b0;
        w_nxt_state = IDLE;
      end
    endcase
  end

  // Bus data changes only on a pop and holds the last entry afterwards.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_gpio <= '0;
      r_addr <= '0;
    end else if (w_pop) begin
      r_gpio <= w_head.data;
      r_addr <= w_head.addr;
    end
  end

  assign gpio_o     = r_gpio;
  assign gpioAddr_o = r_addr;
  assign cs_o       = r_cs;
  assign busy_o     = ~w_empty | (r_state != IDLE);

endmodule

// File: tb/tb_as_gpio_ctrl.sv
// Bench for as_gpio_ctrl: two instances (gap of 1 and gap of 0) driven in lockstep
// and compared every cycle against a transaction-timeline reference model.
module tb_as_gpio_ctrl;

  localparam int DEPTH = 4;
  localparam int HOLD  = 2;

  logic       clk;
  logic       rst_n;
  logic       wr_req;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;

  logic       ack_w   [2];
  logic       stall_w [2];
  logic [7:0] gpio_w  [2];
  logic [3:0] addr_w  [2];
  logic       cs_w    [2];
  logic       busy_w  [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: entries {addr,data}, a start-time schedule per instance.
  logic [11:0] mq [2][DEPTH];
  int          mcnt [2];
  logic [11:0] mcur [2];
  int          last_pop [2];
  int          next_start [2];
  int          k;

  logic       s_ack;
  logic       s_stall;
  logic       prev_cs0;
  logic [7:0] emitted [$];

  typedef struct {
    logic       req;
    logic [3:0] addr;
    logic [7:0] data;
    logic       ack;
    logic       cs;
    logic [7:0] gpio;
    logic [3:0] gaddr;
    logic       busy;
  } vec_t;
  vec_t tbl [5];

  as_gpio_ctrl #(.FIFO_DEPTH(DEPTH), .CS_HOLD(HOLD), .GAP_CYC(1)) dut0 (
    .clk_i(clk), .rst_i(rst_n), .wr_req_i(wr_req), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .wr_ack_o(ack_w[0]), .stall_o(stall_w[0]),
    .gpio_o(gpio_w[0]), .gpioAddr_o(addr_w[0]), .cs_o(cs_w[0]), .busy_o(busy_w[0])
  );

  as_gpio_ctrl #(.FIFO_DEPTH(DEPTH), .CS_HOLD(HOLD), .GAP_CYC(0)) dut1 (
    .clk_i(clk), .rst_i(rst_n), .wr_req_i(wr_req), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .wr_ack_o(ack_w[1]), .stall_o(stall_w[1]),
    .gpio_o(gpio_w[1]), .gpioAddr_o(addr_w[1]), .cs_o(cs_w[1]), .busy_o(busy_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int gap_of(input int m);
    return (m == 0) ? 1 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mcnt[m]       = 0;
      mcur[m]       = '0;
      last_pop[m]   = -100;
      next_start[m] = 0;
    end
  endtask

  task automatic model_edge(input int m, input logic req, input logic [11:0] ent);
    bit acc;
    acc = req && (mcnt[m] < DEPTH);
    if (k >= next_start[m] && mcnt[m] > 0) begin
      mcur[m] = mq[m][0];
      for (int i = 0; i < DEPTH - 1; i++) mq[m][i] = mq[m][i+1];
      mcnt[m]--;
      last_pop[m]   = k;
      next_start[m] = k + HOLD + gap_of(m);
    end
    if (acc) begin
      mq[m][mcnt[m]] = ent;
      mcnt[m]++;
    end
  endtask

  // One clock: drive at negedge, check comb outputs, advance, check registered outputs.
  task automatic step(input logic req, input logic [3:0] a, input logic [7:0] d);
    wr_req  = req;
    wr_addr = a;
    wr_data = d;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("ack[%0d]", m), ack_w[m], req && (mcnt[m] < DEPTH));
      chk($sformatf("stall[%0d]", m), stall_w[m], req && (mcnt[m] == DEPTH));
    end
    s_ack   = ack_w[0];
    s_stall = stall_w[0];
    @(posedge clk);
    if (!rst_n) model_reset();
    else for (int m = 0; m < 2; m++) model_edge(m, req, {a, d});
    k++;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("cs[%0d]", m), cs_w[m],
          (k - 1 >= last_pop[m]) && (k - 1 < last_pop[m] + HOLD));
      chk($sformatf("busy[%0d]", m), busy_w[m],
          (mcnt[m] > 0) || (k - 1 < last_pop[m] + HOLD + gap_of(m)));
      chk($sformatf("gpio[%0d]", m), gpio_w[m], mcur[m][7:0]);
      chk($sformatf("addr[%0d]", m), addr_w[m], mcur[m][11:8]);
    end
    if (cs_w[0] && !prev_cs0) emitted.push_back(gpio_w[0]);
    prev_cs0 = cs_w[0];
  endtask

  initial begin
    int tries;
    int stalls;
    int cs_seen;
    logic       rec_cs [7];
    logic [7:0] rec_g  [7];
    logic       exp6_cs [7];
    logic [7:0] exp6_g  [7];

    // Single write addr=4 data=7 from idle, right after reset.
    tbl[0] = '{req:1'b1, addr:4'd4, data:8'd7, ack:1'b1, cs:1'b0, gpio:8'd0, gaddr:4'd0, busy:1'b1};
    tbl[1] = '{req:1'b0, addr:4'd0, data:8'd0, ack:1'b0, cs:1'b1, gpio:8'd7, gaddr:4'd4, busy:1'b1};
    tbl[2] = '{req:1'b0, addr:4'd0, data:8'd0, ack:1'b0, cs:1'b1, gpio:8'd7, gaddr:4'd4, busy:1'b1};
    tbl[3] = '{req:1'b0, addr:4'd0, data:8'd0, ack:1'b0, cs:1'b0, gpio:8'd7, gaddr:4'd4, busy:1'b1};
    tbl[4] = '{req:1'b0, addr:4'd0, data:8'd0, ack:1'b0, cs:1'b0, gpio:8'd7, gaddr:4'd4, busy:1'b0};

    exp6_cs = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp6_g  = '{8'hA1, 8'hA1, 8'hA1, 8'hB2, 8'hB2, 8'hB2, 8'hB2};

    rst_n    = 1'b0;
    wr_req   = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    k        = 0;
    prev_cs0 = 1'b0;
    model_reset();

    // Reset held for 10 cycles with requests present: nothing may be stored.
    @(negedge clk);
    for (int i = 0; i < 10; i++) step(1'b1, 4'($urandom), 8'($urandom));
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      step(tbl[i].req, tbl[i].addr, tbl[i].data);
      chk($sformatf("tbl%0d_ack", i), s_ack, tbl[i].ack);
      chk($sformatf("tbl%0d_cs", i), cs_w[0], tbl[i].cs);
      chk($sformatf("tbl%0d_gpio", i), gpio_w[0], tbl[i].gpio);
      chk($sformatf("tbl%0d_addr", i), addr_w[0], tbl[i].gaddr);
      chk($sformatf("tbl%0d_busy", i), busy_w[0], tbl[i].busy);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 4'd0, 8'd0);

    // Burst of 8 writes, each held until accepted; order and back-pressure.
    emitted.delete();
    stalls = 0;
    for (int i = 1; i <= 8; i++) begin
      tries = 0;
      do begin
        step(1'b1, 4'(i), 8'(i));
        if (s_stall) stalls++;
        tries++;
      end while (!s_ack && tries < 20);
      if (!s_ack) chk("burst_accept_timeout", 32'd0, 32'd1);
    end
    for (int i = 0; i < 30; i++) step(1'b0, 4'd0, 8'd0);
    chk("burst_stall_seen", (stalls > 0), 1);
    chk("burst_count", emitted.size(), 8);
    for (int i = 0; i < emitted.size() && i < 8; i++)
      chk($sformatf("burst_order%0d", i), emitted[i], i + 1);

    // Async reset in the middle of a drive with entries still queued.
    for (int i = 0; i < 5; i++) step(1'b1, 4'hC, 8'(8'h40 + i));
    chk("pre_rst_cs", cs_w[0], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_cs0", cs_w[0], 1'b0);
    chk("async_cs1", cs_w[1], 1'b0);
    chk("async_busy0", busy_w[0], 1'b0);
    chk("async_gpio0", gpio_w[0], 8'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cs_seen = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 4'd0, 8'd0);
      if (cs_w[0] || cs_w[1]) cs_seen++;
    end
    chk("post_rst_no_pulse", cs_seen, 0);
    chk("post_rst_busy", busy_w[0], 1'b0);

    // Zero-gap instance: A then B give one continuous 4-cycle cs_o window.
    for (int i = 0; i < 7; i++) begin
      if (i == 0)      step(1'b1, 4'd2, 8'hA1);
      else if (i == 1) step(1'b1, 4'd3, 8'hB2);
      else             step(1'b0, 4'd0, 8'd0);
      rec_cs[i] = cs_w[1];
      rec_g[i]  = gpio_w[1];
    end
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("gap0_cs%0d", i), rec_cs[i], exp6_cs[i]);
      if (i > 0) chk($sformatf("gap0_gpio%0d", i), rec_g[i], exp6_g[i]);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 4'd0, 8'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 2) != 0, 4'($urandom), 8'($urandom));
    for (int i = 0; i < 20; i++) step(1'b0, 4'd0, 8'd0);
    chk("final_busy0", busy_w[0], 1'b0);
    chk("final_busy1", busy_w[1], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
